// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN stack calculator.
package rpn_pkg;

  typedef enum logic [1:0] {
    TK_NUMBER   = 2'd0,
    TK_OPERATOR = 2'd1,
    TK_END      = 2'd2,
    TK_CLEAR    = 2'd3
  } tok_kind_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_UNDERFLOW = 3'd1,
    ERR_OVERFLOW  = 3'd2,
    ERR_DIV_ZERO  = 3'd3,
    ERR_BAD_OP    = 3'd4,
    ERR_MALFORMED = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_DIV    = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;
  localparam logic [7:0] OP_DIV = 8'h2F;

endpackage

// File: rtl/rpn_divider.sv
// Restoring shift-subtract unsigned divider; done pulses exactly WIDTH cycles after start.
// The first iteration is taken on the start edge so the quotient is registered when done rises.
module rpn_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH-1:0] nxt_rem, nxt_quo;
  logic [WIDTH:0]   shifted, diff;

  // One restoring step; a borrow out of the trial subtraction keeps the old remainder.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    shifted = {src_rem, src_quo[WIDTH-1]};
    diff    = shifted - {1'b0, src_dvs};
    if (diff[WIDTH]) begin
      nxt_rem = shifted[WIDTH-1:0];
      nxt_quo = {src_quo[WIDTH-2:0], 1'b0};
    end else begin
      nxt_rem = diff[WIDTH-1:0];
      nxt_quo = {src_quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= nxt_rem;
        quo_q  <= nxt_quo;
        dvs_q  <= divisor;
        cnt_q  <= CW'(1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= nxt_rem;
        quo_q <= nxt_quo;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/rpn_stack_calc.sv
// Reverse-Polish integer evaluator over a token valid/ready stream with an operand stack.
module rpn_stack_calc
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         TOK_VALID,
  output logic                         TOK_READY,
  input  logic [1:0]                   TOK_KIND,
  input  logic [WIDTH-1:0]             TOK_DATA,
  output logic                         RES_VALID,
  output logic [WIDTH-1:0]             RES_DATA,
  output logic                         ERR,
  output logic [2:0]                   ERR_CODE,
  output logic [$clog2(DEPTH+1)-1:0]   DEPTH_OUT,
  output logic                         BUSY
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

  state_e    state_q, state_nxt;
  err_code_e err_ev, code_q, code_nxt;
  tok_kind_e kind;
  logic [7:0] op;
  logic       tok_fire;

  logic [WIDTH-1:0] stk [DEPTH];
  logic [DW-1:0]    dcnt_q, dcnt_nxt;
  logic [IW-1:0]    top_idx, nos_idx, push_idx, wr_idx;
  logic [WIDTH-1:0] top_w, nos_w, wr_data, res_data_nxt;
  logic             wr_en, res_valid_nxt, err_nxt, div_start, div_done;
  logic [WIDTH-1:0] quotient;

  assign kind     = tok_kind_e'(TOK_KIND);
  assign op       = TOK_DATA[7:0];
  assign tok_fire = TOK_VALID & TOK_READY;

  assign top_idx  = IW'(dcnt_q - DW'(1));
  assign nos_idx  = IW'(dcnt_q - DW'(2));
  assign push_idx = IW'(dcnt_q);
  assign top_w    = stk[top_idx];
  assign nos_w    = stk[nos_idx];

  rpn_divider #(.WIDTH(WIDTH)) u_div (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (div_start),
    .dividend (nos_w),
    .divisor  (top_w),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_ACCEPT;
    else        state_q <= state_nxt;
  end

  // Next state, plus the error classification of the accepted token.
  always_comb begin
    state_nxt = state_q;
    err_ev    = ERR_NONE;
    case (state_q)
      ST_ACCEPT: begin
        if (tok_fire) begin
          case (kind)
            TK_NUMBER:   if (dcnt_q == DEPTH_FULL) err_ev = ERR_OVERFLOW;
            TK_OPERATOR: begin
              if (dcnt_q < DW'(2)) err_ev = ERR_UNDERFLOW;
              else begin
                case (op)
                  OP_ADD, OP_SUB, OP_MUL: ;
                  OP_DIV: begin
                    if (top_w == '0) err_ev = ERR_DIV_ZERO;
                    else             state_nxt = ST_DIV;
                  end
                  default: err_ev = ERR_BAD_OP;
                endcase
              end
            end
            TK_END:   if (dcnt_q != DW'(1)) err_ev = ERR_MALFORMED;
            TK_CLEAR: ;
          endcase
          if (err_ev != ERR_NONE) state_nxt = ST_ERROR;
        end
      end
      ST_DIV:   if (div_done) state_nxt = ST_ACCEPT;
      ST_ERROR: if (tok_fire && kind == TK_CLEAR) state_nxt = ST_ACCEPT;
      default:  state_nxt = ST_ACCEPT;
    endcase
  end

  // Datapath next values: stack write, depth, result and error registers.
  always_comb begin
    dcnt_nxt      = dcnt_q;
    wr_en         = 1'b0;
    wr_idx        = nos_idx;
    wr_data       = '0;
    res_valid_nxt = 1'b0;
    res_data_nxt  = RES_DATA;
    err_nxt       = ERR;
    code_nxt      = code_q;
    div_start     = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (tok_fire && err_ev != ERR_NONE) begin
          err_nxt  = 1'b1;
          code_nxt = err_ev;
        end else if (tok_fire) begin
          case (kind)
            TK_NUMBER: begin
              wr_en    = 1'b1;
              wr_idx   = push_idx;
              wr_data  = TOK_DATA;
              dcnt_nxt = dcnt_q + DW'(1);
            end
            TK_OPERATOR: begin
              case (op)
                OP_ADD: wr_data = nos_w + top_w;
                OP_SUB: wr_data = nos_w - top_w;
                OP_MUL: wr_data = nos_w * top_w;
                default: wr_data = '0;
              endcase
              if (op == OP_DIV) div_start = 1'b1;
              else begin
                wr_en    = 1'b1;
                dcnt_nxt = dcnt_q - DW'(1);
              end
            end
            TK_END: begin
              res_valid_nxt = 1'b1;
              res_data_nxt  = top_w;
              dcnt_nxt      = '0;
            end
            TK_CLEAR: dcnt_nxt = '0;
          endcase
        end
      end
      ST_DIV: begin
        if (div_done) begin
          wr_en    = 1'b1;
          wr_data  = quotient;
          dcnt_nxt = dcnt_q - DW'(1);
        end
      end
      ST_ERROR: begin
        if (tok_fire && kind == TK_CLEAR) begin
          dcnt_nxt = '0;
          err_nxt  = 1'b0;
          code_nxt = ERR_NONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dcnt_q    <= '0;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      ERR       <= 1'b0;
      code_q    <= ERR_NONE;
      TOK_READY <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      dcnt_q    <= dcnt_nxt;
      RES_VALID <= res_valid_nxt;
      RES_DATA  <= res_data_nxt;
      ERR       <= err_nxt;
      code_q    <= code_nxt;
      TOK_READY <= (state_nxt != ST_DIV);
      BUSY      <= (state_nxt == ST_DIV);
    end
  end

  // Stack contents carry no reset; occupancy alone defines what is valid.
  always_ff @(posedge CLK) begin
    if (wr_en) stk[wr_idx] <= wr_data;
  end

  assign ERR_CODE  = code_q;
  assign DEPTH_OUT = dcnt_q;

endmodule

// File: doc/rpn_stack_calc.md
# rpn_stack_calc

Parametrised reverse-Polish integer evaluator. It accepts a stream of number and operator tokens over a valid/ready handshake and evaluates them on an internal operand stack. On an END token it returns a single result. It is the next generation of the team's strobe-driven calculator: width and depth are configurable, operand order is fixed, division is multi-cycle, and it detects underflow, overflow, divide-by-zero and malformed expressions.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥8)
- DEPTH, 16, operand stack entries (≥2)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- TOK_VALID  in  1  token present
- TOK_READY  out  1  block accepts token this cycle
- TOK_KIND  in  2  0=NUMBER, 1=OPERATOR, 2=END, 3=CLEAR
- TOK_DATA  in  WIDTH  number value; for OPERATOR, ASCII code in [7:0]
- RES_VALID  out  1  one-cycle result strobe
- RES_DATA  out  WIDTH  result, held until next RES_VALID
- ERR  out  1  sticky error flag
- ERR_CODE  out  3  0=none, 1=underflow, 2=overflow, 3=div-by-zero, 4=bad operator, 5=malformed
- DEPTH_OUT  out  $clog2(DEPTH+1)  current stack occupancy
- BUSY  out  1  high while in DIV

## Operation
- A token is accepted on a cycle where TOK_VALID and TOK_READY are both high. TOK_READY is high in ACCEPT and ERROR, and low in DIV.
- States: ACCEPT, DIV, ERROR. RES_VALID is a registered strobe, not a state.
- ACCEPT, NUMBER:
  - If depth < DEPTH: push the value, depth+1.
  - If depth = DEPTH: go to ERROR, code 2.
- ACCEPT, OPERATOR: requires depth ≥ 2, otherwise ERROR code 1.
  - Operands: a = next-on-stack, b = top. The result replaces both entries, depth−1.
  - '+' gives a+b, '-' gives a−b, '*' gives low WIDTH bits of a·b. All arithmetic is unsigned, modulo 2^WIDTH, and completes in one cycle.
  - '/' with b=0: ERROR code 3, stack unchanged.
  - '/' otherwise: start the divider and go to DIV.
  - Any other code: ERROR code 4.
- DIV: runs for WIDTH cycles. Then floor(a/b) replaces both entries, depth−1, and the state returns to ACCEPT.
- ACCEPT, END:
  - depth = 1: RES_DATA ← top, RES_VALID pulses, stack empties.
  - Any other depth: ERROR code 5.
- ACCEPT, CLEAR: empty the stack. RES and ERR are unaffected.
- ERROR: ERR=1 and ERR_CODE are held. Every token is accepted. Tokens other than CLEAR are dropped. CLEAR empties the stack, clears ERR/ERR_CODE and returns to ACCEPT.
- Reset values: TOK_READY=1, RES_VALID=0, RES_DATA=0, ERR=0, ERR_CODE=0, DEPTH_OUT=0, BUSY=0, state ACCEPT.
- Reset asserted mid-division aborts the division with no partial write.

## Timing
- Stack update, DEPTH_OUT and ERR/ERR_CODE are valid the cycle after the token is accepted.
- A token can be accepted every cycle in ACCEPT. Back-to-back number/operator tokens need no bubble.
- RES_VALID goes high the cycle after END is accepted, for exactly one cycle. A NUMBER accepted in that same cycle starts a fresh expression.
- '/' accepted at cycle t:
  - TOK_READY and BUSY are low for cycles t+1 … t+WIDTH.
  - The quotient is on the stack and TOK_READY is high at t+WIDTH+1.
- TOK_VALID may be held high while TOK_READY is low. The token is not consumed and TOK_DATA must stay stable.

## Structure
- Package rpn_pkg holds:
  - token-kind enum
  - ERR_CODE enum
  - FSM state enum
  - operator ASCII constants '+', '-', '*', '/'
- Sub-module rpn_divider:
  - restoring shift-subtract unsigned divider, parameter WIDTH
  - ports: start, dividend, divisor, done, quotient
  - exactly WIDTH cycles from start to done
  - asynchronous active-low reset shared with the parent
- The stack is a register array indexed by a depth counter. The top and next-on-stack read ports are combinational.

## Test plan
- "3 4 + END" (WIDTH=32) → RES_DATA=7 with a one-cycle RES_VALID; DEPTH_OUT returns to 0; ERR=0.
- "20 4 - 3 * END" → 48; then "0xFFFFFFFF 1 + END" → 0 (wrap); "0x10000 0x10000 * END" → 0.
- "100 7 / END" → TOK_READY low for exactly 32 cycles, then 14; "7 100 / END" → 0.
- "5 0 /" → ERR=1, code 3; a following "1 2 +" is dropped and DEPTH_OUT stays 2; CLEAR → ERR=0, depth 0; "2 2 * END" → 4.
- DEPTH=4, error cases (each followed by CLEAR before the next):
  - push 5 numbers → code 2 on the fifth
  - "9 +" → code 1
  - "1 2 END" → code 5
  - operator '%' → code 4
- RST_N pulsed low mid-division → all outputs at reset values; after release TOK_READY=1 and DEPTH_OUT=0; "6 3 / END" → 2.
